// File: rtl/addsub_arbiter.sv
// ============================================================================
// Module   : addsub_arbiter
// Brief    : Two-port round-robin arbiter/sequencer for a shared 4-bit
//            two's-complement adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic       sub0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic       sub1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] r,
   output logic       ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic       sub_q, sub_d;
   logic [3:0] r_q, r_d;
   logic       ovf_q, ovf_d;

   logic [3:0] w_bx;
   logic [3:0] w_sum;
   logic       w_ovf;
   logic       w_pick;

   // The single shared adder/subtractor: subtraction is A + ~B + 1.
   assign w_bx  = b_q ^ {4{sub_q}};
   assign w_sum = a_q + w_bx + {3'b000, sub_q};
   assign w_ovf = (a_q[3] & w_bx[3] & ~w_sum[3]) | (~a_q[3] & ~w_bx[3] & w_sum[3]);

   // On a tie, the requester that was not served last wins.
   assign w_pick = (req0 && req1) ? ~last_q : req1;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      r_d     = r_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d = w_pick;
               a_d     = w_pick ? a1 : a0;
               b_d     = w_pick ? b1 : b0;
               sub_d   = w_pick ? sub1 : sub0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            r_d     = w_sum;
            ovf_d   = w_ovf;
            state_d = DONE;
         end
         DONE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         sub_q   <= 1'b0;
         r_q     <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         r_q     <= r_d;
         ovf_q   <= ovf_d;
      end
   end

   assign gnt0  = ((state_q == EXEC) || (state_q == DONE)) && !owner_q;
   assign gnt1  = ((state_q == EXEC) || (state_q == DONE)) &&  owner_q;
   assign done0 = (state_q == DONE) && !owner_q;
   assign done1 = (state_q == DONE) &&  owner_q;
   assign r     = r_q;
   assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
// ============================================================================
// Module   : tb_addsub_arbiter
// Brief    : Directed self-checking bench for addsub_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_arbiter;

   logic       clk;
   logic       reset;
   logic       req0, req1, sub0, sub1;
   logic [3:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, done0, done1, ovf;
   logic [3:0] r;

   int n_chk;
   int n_fail;

   addsub_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .a0    (a0),
      .b0    (b0),
      .sub0  (sub0),
      .req1  (req1),
      .a1    (a1),
      .b1    (b1),
      .sub1  (sub1),
      .gnt0  (gnt0),
      .gnt1  (gnt1),
      .done0 (done0),
      .done1 (done1),
      .r     (r),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctrl(input string tag, input logic g0, input logic g1,
                             input logic d0, input logic d1);
      check({tag, ".gnt"},  {6'd0, gnt1, gnt0},   {6'd0, g1, g0});
      check({tag, ".done"}, {6'd0, done1, done0}, {6'd0, d1, d0});
   endtask

   // Single-requester operation; request dropped right after the grant.
   task automatic do_op(input string tag, input logic port, input logic [3:0] a,
                        input logic [3:0] b, input logic sub,
                        input logic [3:0] exp_r, input logic exp_ovf);
      if (!port) begin a0 = a; b0 = b; sub0 = sub; req0 = 1'b1; end
      else       begin a1 = a; b1 = b; sub1 = sub; req1 = 1'b1; end
      tick();
      check_ctrl({tag, ".c1"}, !port, port, 1'b0, 1'b0);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check_ctrl({tag, ".c2"}, !port, port, !port, port);
      check({tag, ".r"},   {4'd0, r},   {4'd0, exp_r});
      check({tag, ".ovf"}, {7'd0, ovf}, {7'd0, exp_ovf});
      tick();
      check_ctrl({tag, ".c3"}, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [7:0] exp_g[1:8];
   logic [7:0] exp_d[1:8];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      tick();
      tick();
      check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.r", {3'd0, ovf, r}, 8'h00);
      reset = 1'b0;

      do_op("add3p2",  1'b0, 4'd3,    4'd2, 1'b0, 4'b0101, 1'b0);
      do_op("sub3m5",  1'b1, 4'd3,    4'd5, 1'b1, 4'b1110, 1'b0);
      do_op("add7p1",  1'b0, 4'd7,    4'd1, 1'b0, 4'b1000, 1'b1);
      do_op("subm8m1", 1'b0, 4'b1000, 4'd1, 1'b1, 4'b0111, 1'b1);

      // Continuous contention straight out of reset: grants 0,1,0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a0 = 4'd2; b0 = 4'd3; sub0 = 1'b0;   // 5
      a1 = 4'd6; b1 = 4'd2; sub1 = 1'b1;   // 4
      req0 = 1'b1;
      req1 = 1'b1;
      exp_g = '{8'h1, 8'h1, 8'h0, 8'h2, 8'h2, 8'h0, 8'h1, 8'h1};
      exp_d = '{8'h0, 8'h1, 8'h0, 8'h0, 8'h2, 8'h0, 8'h0, 8'h1};
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("tie.gnt%0d", k),  {6'd0, gnt1, gnt0},   exp_g[k]);
         check($sformatf("tie.done%0d", k), {6'd0, done1, done0}, exp_d[k]);
         if (k == 2 || k == 8) check($sformatf("tie.r%0d", k), {3'd0, ovf, r}, 8'h05);
         if (k == 5)           check("tie.r5", {3'd0, ovf, r}, 8'h04);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();

      // Reset during EXEC aborts the op and restores round-robin priority.
      a1 = 4'd1; b1 = 4'd1; sub1 = 1'b0;
      req1 = 1'b1;
      tick();
      check_ctrl("abort.c1", 1'b0, 1'b1, 1'b0, 1'b0);
      req1  = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_ctrl("abort.c2", 1'b0, 1'b0, 1'b0, 1'b0);
      check("abort.r", {3'd0, ovf, r}, 8'h00);
      tick();
      check_ctrl("abort.c3", 1'b0, 1'b0, 1'b0, 1'b0);
      a0 = 4'd1; b0 = 4'd1; sub0 = 1'b0;
      a1 = 4'd4; b1 = 4'd4; sub1 = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      check_ctrl("abort.tie", 1'b1, 1'b0, 1'b0, 1'b0);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check_ctrl("abort.done", 1'b1, 1'b0, 1'b1, 1'b0);
      check("abort.res", {3'd0, ovf, r}, 8'h02);
      tick();

      // Operands changed after the grant must not affect the result.
      a0 = 4'd5; b0 = 4'd1; sub0 = 1'b1;
      req0 = 1'b1;
      tick();
      check_ctrl("latch.c1", 1'b1, 1'b0, 1'b0, 1'b0);
      a0 = 4'd7; b0 = 4'd7; sub0 = 1'b0;
      req0 = 1'b0;
      tick();
      check_ctrl("latch.c2", 1'b1, 1'b0, 1'b1, 1'b0);
      check("latch.r", {3'd0, ovf, r}, 8'h04);
      tick();
      check_ctrl("latch.c3", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
